sensor_uart_arbiter: RTL and testbench

SENSOR_UART_ARBITER -- requirements
Module: sensor_uart_arbiter

---
 rtl/sensor_arb_pkg.sv | 23 ++
 rtl/sensor_arb_rr.sv | 33 +++
 rtl/sensor_uart_arbiter.sv | 124 ++++++++++++
 tb/tb_sensor_uart_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_arb_pkg.sv
// Shared types and constants for the sensor UART arbiter.
// Optional checksum byte is enabled by defining SENSOR_ARB_CHECKSUM_EN.
package sensor_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_t;

    typedef enum logic {
        SRC_MPR = 1'b0,
        SRC_ADS = 1'b1
    } src_t;

    localparam logic [7:0] ADS_HDR_DEF = 8'hA0;
    localparam logic [7:0] MPR_HDR_DEF = 8'hB0;
    localparam int         ADS_BYTES   = 6;
    localparam int         MPR_BYTES   = 2;
    localparam int         CNT_W       = 3;

endpackage

// File: rtl/sensor_arb_rr.sv
// Two-input round-robin grant; a tie goes to the source not granted last.
module sensor_arb_rr
    import sensor_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ads,
    input  logic req_mpr,
    input  logic take,
    output logic grant_any,
    output src_t grant
);

    src_t last;

    always_comb begin
        grant_any = req_ads | req_mpr;
        if (req_ads && req_mpr)
            grant = (last == SRC_MPR) ? SRC_ADS : SRC_MPR;
        else if (req_ads)
            grant = SRC_ADS;
        else
            grant = SRC_MPR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= SRC_MPR;
        else if (take)
            last <= grant;
    end

endmodule

// File: rtl/sensor_uart_arbiter.sv
// Packs ADS1292 / MPR121 samples into header+payload(+checksum) UART byte streams.
// Define SENSOR_ARB_CHECKSUM_EN to append the XOR checksum byte.
module sensor_uart_arbiter
    import sensor_arb_pkg::*;
#(
    parameter logic [7:0] ADS_HDR = ADS_HDR_DEF,
    parameter logic [7:0] MPR_HDR = MPR_HDR_DEF
)(
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_ADS_REQ,
    input  logic [47:0] i_ADS_DATA,
    output logic        o_ADS_ACK,
    input  logic        i_MPR_REQ,
    input  logic [15:0] i_MPR_DATA,
    output logic        o_MPR_ACK,
    output logic [7:0]  o_UART_DATA,
    output logic        o_UART_VALID,
    input  logic        i_UART_READY,
    output logic        o_BUSY
);

    state_t           state, state_nxt;
    src_t             src, grant;
    logic             grant_any, take, xfer, last_byte;
    logic [47:0]      latch;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       pay_byte;

    assign take      = (state == ST_IDLE) && grant_any;
    assign xfer      = o_UART_VALID && i_UART_READY;
    assign last_byte = (cnt == ((src == SRC_ADS) ? CNT_W'(ADS_BYTES - 1) : CNT_W'(MPR_BYTES - 1)));
    // MPR data is latched left-aligned so both sources share one MSB-first byte select
    assign pay_byte  = 8'(latch >> (6'd40 - {cnt, 3'b000}));
    assign o_BUSY    = (state != ST_IDLE);

    sensor_arb_rr u_rr (
        .clk       (i_CLK),
        .rst       (i_RST),
        .req_ads   (i_ADS_REQ),
        .req_mpr   (i_MPR_REQ),
        .take      (take),
        .grant_any (grant_any),
        .grant     (grant)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (grant_any) state_nxt = ST_HDR;
            ST_HDR:     if (xfer) state_nxt = ST_PAYLOAD;
`ifdef SENSOR_ARB_CHECKSUM_EN
            ST_PAYLOAD: if (xfer && last_byte) state_nxt = ST_CSUM;
            ST_CSUM:    if (xfer) state_nxt = ST_IDLE;
`else
            ST_PAYLOAD: if (xfer && last_byte) state_nxt = ST_IDLE;
`endif
            default:    state_nxt = ST_IDLE;
        endcase
    end

`ifdef SENSOR_ARB_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            csum <= '0;
        else if (take)
            csum <= (grant == SRC_ADS) ? ADS_HDR : MPR_HDR;
        else if (state == ST_PAYLOAD && xfer)
            csum <= csum ^ pay_byte;
    end
`endif

    always_comb begin
        o_UART_VALID = 1'b0;
        o_UART_DATA  = '0;
        case (state)
            ST_HDR: begin
                o_UART_VALID = 1'b1;
                o_UART_DATA  = (src == SRC_ADS) ? ADS_HDR : MPR_HDR;
            end
            ST_PAYLOAD: begin
                o_UART_VALID = 1'b1;
                o_UART_DATA  = pay_byte;
            end
`ifdef SENSOR_ARB_CHECKSUM_EN
            ST_CSUM: begin
                o_UART_VALID = 1'b1;
                o_UART_DATA  = csum;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            src       <= SRC_MPR;
            latch     <= '0;
            cnt       <= '0;
            o_ADS_ACK <= 1'b0;
            o_MPR_ACK <= 1'b0;
        end else begin
            o_ADS_ACK <= take && (grant == SRC_ADS);
            o_MPR_ACK <= take && (grant == SRC_MPR);
            if (take) begin
                src   <= grant;
                latch <= (grant == SRC_ADS) ? i_ADS_DATA : {i_MPR_DATA, 32'h0};
                cnt   <= '0;
            end else if (state == ST_PAYLOAD && xfer) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_uart_arbiter.sv
// Randomized self-checking bench for sensor_uart_arbiter against a packet-level model.
// Honors SENSOR_ARB_CHECKSUM_EN the same way the design does.
module tb_sensor_uart_arbiter;

    localparam logic [7:0] ADS_H = 8'hA0;
    localparam logic [7:0] MPR_H = 8'hB0;

    logic        i_CLK, i_RST;
    logic        i_ADS_REQ, i_MPR_REQ, i_UART_READY;
    logic [47:0] i_ADS_DATA;
    logic [15:0] i_MPR_DATA;
    logic        o_ADS_ACK, o_MPR_ACK, o_UART_VALID, o_BUSY;
    logic [7:0]  o_UART_DATA;

    int checks = 0;
    int errors = 0;
    int ads_acks = 0;
    int mpr_acks = 0;
    bit rand_ready = 0;
    bit model_last_ads = 0;
    bit stall_prev = 0;
    logic [7:0] stall_data;
    logic [7:0] got[$];
    logic [7:0] exp[$];

    sensor_uart_arbiter dut (
        .i_CLK        (i_CLK),
        .i_RST        (i_RST),
        .i_ADS_REQ    (i_ADS_REQ),
        .i_ADS_DATA   (i_ADS_DATA),
        .o_ADS_ACK    (o_ADS_ACK),
        .i_MPR_REQ    (i_MPR_REQ),
        .i_MPR_DATA   (i_MPR_DATA),
        .o_MPR_ACK    (o_MPR_ACK),
        .o_UART_DATA  (o_UART_DATA),
        .o_UART_VALID (o_UART_VALID),
        .i_UART_READY (i_UART_READY),
        .o_BUSY       (o_BUSY)
    );

    initial begin
        i_CLK = 0;
        forever #5 i_CLK = ~i_CLK;
    end

    initial forever begin
        @(posedge i_CLK);
        #1;
        if (rand_ready) i_UART_READY = ($urandom_range(0, 3) != 0);
    end

    // Packet model: header, payload MSB first, optional XOR of everything before it
    function automatic void add_pkt(input bit ads, input logic [47:0] d);
        int n;
        logic [7:0] b, cs;
        n  = ads ? 6 : 2;
        cs = ads ? ADS_H : MPR_H;
        exp.push_back(cs);
        for (int i = 0; i < n; i++) begin
            b  = 8'(d >> (8 * (n - 1 - i)));
            cs = cs ^ b;
            exp.push_back(b);
        end
`ifdef SENSOR_ARB_CHECKSUM_EN
        exp.push_back(cs);
`endif
    endfunction

    // Byte capture plus continuous ACK-placement and backpressure-stability checks
    always @(negedge i_CLK) begin
        if (!i_RST) begin
            if (o_UART_VALID && i_UART_READY) got.push_back(o_UART_DATA);
            if (o_ADS_ACK) begin
                ads_acks++;
                checks++;
                if (!(o_UART_VALID && o_UART_DATA === ADS_H)) begin
                    errors++;
                    $display("FAIL ads_ack_place: valid=%b data=%02h, required valid=1 data=%02h", o_UART_VALID, o_UART_DATA, ADS_H);
                end
            end
            if (o_MPR_ACK) begin
                mpr_acks++;
                checks++;
                if (!(o_UART_VALID && o_UART_DATA === MPR_H)) begin
                    errors++;
                    $display("FAIL mpr_ack_place: valid=%b data=%02h, required valid=1 data=%02h", o_UART_VALID, o_UART_DATA, MPR_H);
                end
            end
            if (stall_prev) begin
                checks++;
                if (!(o_UART_VALID === 1'b1 && o_UART_DATA === stall_data)) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%02h, required valid=1 data=%02h", o_UART_VALID, o_UART_DATA, stall_data);
                end
            end
            stall_prev = o_UART_VALID && !i_UART_READY;
            stall_data = o_UART_DATA;
        end else begin
            stall_prev = 0;
        end
    end

    task automatic apply_reset();
        i_RST = 1; i_ADS_REQ = 0; i_MPR_REQ = 0;
        rand_ready = 0; i_UART_READY = 1;
        @(posedge i_CLK);
        @(negedge i_CLK);
        i_RST = 0;
        model_last_ads = 0;
        got.delete();
        exp.delete();
    endtask

    task automatic send_ads(input logic [47:0] d);
        int n = 0;
        i_ADS_DATA = d; i_ADS_REQ = 1;
        do begin @(negedge i_CLK); #1; n++; end while (!o_ADS_ACK && n < 400);
        checks++;
        if (!o_ADS_ACK) begin errors++; $display("FAIL ads_ack_timeout: ack=%b, required 1", o_ADS_ACK); end
        @(posedge i_CLK); #1;
        i_ADS_REQ = 0;
    endtask

    task automatic send_mpr(input logic [15:0] d);
        int n = 0;
        i_MPR_DATA = d; i_MPR_REQ = 1;
        do begin @(negedge i_CLK); #1; n++; end while (!o_MPR_ACK && n < 400);
        checks++;
        if (!o_MPR_ACK) begin errors++; $display("FAIL mpr_ack_timeout: ack=%b, required 1", o_MPR_ACK); end
        @(posedge i_CLK); #1;
        i_MPR_REQ = 0;
    endtask

    task automatic wait_stream(input int n);
        int k = 0;
        do begin @(negedge i_CLK); #1; k++; end while (!(got.size() >= n && !o_BUSY) && k < 2000);
        checks++;
        if (k >= 2000) begin errors++; $display("FAIL stream_timeout: got %0d bytes, required %0d", got.size(), n); end
    endtask

    task automatic test_reset();
        i_RST = 1; i_ADS_REQ = 0; i_MPR_REQ = 0; i_UART_READY = 1;
        i_ADS_DATA = '0; i_MPR_DATA = '0;
        @(posedge i_CLK); @(negedge i_CLK);
        checks += 5;
        if (o_UART_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", o_UART_VALID); end
        if (o_UART_DATA !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h, required 00", o_UART_DATA); end
        if (o_ADS_ACK !== 1'b0) begin errors++; $display("FAIL rst_ads_ack: got %b, required 0", o_ADS_ACK); end
        if (o_MPR_ACK !== 1'b0) begin errors++; $display("FAIL rst_mpr_ack: got %b, required 0", o_MPR_ACK); end
        if (o_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", o_BUSY); end
        i_RST = 0;
    endtask

    task automatic test_ads_only();
        int a0, m0;
        apply_reset();
        a0 = ads_acks; m0 = mpr_acks;
        add_pkt(1, 48'h123456789ABC);
        @(posedge i_CLK); #1;
        send_ads(48'h123456789ABC);
        wait_stream(exp.size());
        checks += 3;
        if (ads_acks - a0 != 1) begin errors++; $display("FAIL ads_only_acks: got %0d, required 1", ads_acks - a0); end
        if (mpr_acks - m0 != 0) begin errors++; $display("FAIL ads_only_mpr_acks: got %0d, required 0", mpr_acks - m0); end
        if (got.size() != exp.size()) begin errors++; $display("FAIL ads_only_len: got %0d, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL ads_only_byte%0d: got %02h, required %02h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_mpr_only();
        int a0, m0;
        apply_reset();
        a0 = ads_acks; m0 = mpr_acks;
        add_pkt(0, 48'h0F01);
        @(posedge i_CLK); #1;
        send_mpr(16'h0F01);
        wait_stream(exp.size());
        checks += 3;
        if (mpr_acks - m0 != 1) begin errors++; $display("FAIL mpr_only_acks: got %0d, required 1", mpr_acks - m0); end
        if (ads_acks - a0 != 0) begin errors++; $display("FAIL mpr_only_ads_acks: got %0d, required 0", ads_acks - a0); end
        if (got.size() != exp.size()) begin errors++; $display("FAIL mpr_only_len: got %0d, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL mpr_only_byte%0d: got %02h, required %02h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_tie();
        logic [47:0] da;
        logic [15:0] dm;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            da = {16'($urandom()), $urandom()};
            dm = 16'($urandom());
            // A tie goes to whoever was not granted last; the last-grant is unchanged afterwards
            if (!model_last_ads) begin add_pkt(1, da); add_pkt(0, dm); end
            else begin add_pkt(0, dm); add_pkt(1, da); end
            @(posedge i_CLK); #1;
            fork
                send_ads(da);
                send_mpr(dm);
            join
            wait_stream(exp.size());
        end
        checks += 2;
        if (got.size() != exp.size()) begin errors++; $display("FAIL tie_len: got %0d, required %0d", got.size(), exp.size()); end
        if (got.size() > 0 && got[0] !== ADS_H) begin errors++; $display("FAIL tie_first_hdr: got %02h, required %02h", got[0], ADS_H); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL tie_byte%0d: got %02h, required %02h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        add_pkt(1, 48'h123456789ABC);
        @(posedge i_CLK); #1;
        i_ADS_DATA = 48'h123456789ABC; i_ADS_REQ = 1;
        do @(negedge i_CLK); while (!o_ADS_ACK && !o_BUSY);
        @(posedge i_CLK); #1;
        i_ADS_REQ = 0; i_UART_READY = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_CLK);
            checks++;
            if (!(o_UART_VALID === 1'b1 && o_UART_DATA === 8'h12)) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%02h, required valid=1 data=12", c, o_UART_VALID, o_UART_DATA);
            end
        end
        @(posedge i_CLK); #1;
        i_UART_READY = 1;
        wait_stream(exp.size());
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL bp_len: got %0d, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d: got %02h, required %02h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int a0, n;
        apply_reset();
        @(posedge i_CLK); #1;
        i_ADS_DATA = 48'h123456789ABC; i_ADS_REQ = 1;
        n = 0;
        do begin @(negedge i_CLK); #1; n++; end while (got.size() < 3 && n < 100);
        @(posedge i_CLK); #2;
        i_RST = 1;
        #1;
        checks += 4;
        if (o_UART_VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", o_UART_VALID); end
        if (o_UART_DATA !== 8'h00) begin errors++; $display("FAIL midrst_data: got %02h, required 00", o_UART_DATA); end
        if (o_BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", o_BUSY); end
        if (o_ADS_ACK !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b, required 0", o_ADS_ACK); end
        got.delete();
        exp.delete();
        a0 = ads_acks;
        add_pkt(1, 48'h123456789ABC);
        @(posedge i_CLK);
        @(negedge i_CLK);
        i_RST = 0;
        n = 0;
        do begin @(negedge i_CLK); #1; n++; end while (!o_ADS_ACK && n < 50);
        @(posedge i_CLK); #1;
        i_ADS_REQ = 0;
        wait_stream(exp.size());
        checks += 2;
        if (ads_acks - a0 != 1) begin errors++; $display("FAIL midrst_acks: got %0d, required 1", ads_acks - a0); end
        if (got.size() != exp.size()) begin errors++; $display("FAIL midrst_len: got %0d, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL midrst_byte%0d: got %02h, required %02h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_busy_arrival();
        logic [47:0] da;
        logic [15:0] dm;
        int n;
        apply_reset();
        da = {16'($urandom()), $urandom()};
        dm = 16'($urandom());
        add_pkt(1, da);
        add_pkt(0, dm);
        @(posedge i_CLK); #1;
        send_ads(da);
        i_MPR_DATA = dm; i_MPR_REQ = 1;
        n = 0;
        do begin
            @(negedge i_CLK); n++;
            checks++;
            if (o_MPR_ACK !== 1'b0) begin errors++; $display("FAIL busy_no_ack: got %b, required 0", o_MPR_ACK); end
        end while (o_BUSY && n < 100);
        checks++;
        if (o_UART_VALID !== 1'b0) begin errors++; $display("FAIL busy_idle_gap: valid=%b, required 0", o_UART_VALID); end
        @(negedge i_CLK);
        checks++;
        if (o_MPR_ACK !== 1'b1) begin errors++; $display("FAIL busy_mpr_ack: got %b, required 1", o_MPR_ACK); end
        @(posedge i_CLK); #1;
        i_MPR_REQ = 0;
        wait_stream(exp.size());
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL busy_len: got %0d, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL busy_byte%0d: got %02h, required %02h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_random();
        logic [47:0] da;
        logic [15:0] dm;
        int mode, a0, m0, ea, em;
        apply_reset();
        a0 = ads_acks; m0 = mpr_acks; ea = 0; em = 0;
        rand_ready = 1;
        for (int r = 0; r < 20; r++) begin
            mode = $urandom_range(0, 2);
            da = {16'($urandom()), $urandom()};
            dm = 16'($urandom());
            @(posedge i_CLK); #1;
            if (mode == 0) begin
                add_pkt(1, da); model_last_ads = 1; ea++;
                send_ads(da);
            end else if (mode == 1) begin
                add_pkt(0, dm); model_last_ads = 0; em++;
                send_mpr(dm);
            end else begin
                if (!model_last_ads) begin add_pkt(1, da); add_pkt(0, dm); end
                else begin add_pkt(0, dm); add_pkt(1, da); end
                ea++; em++;
                fork
                    send_ads(da);
                    send_mpr(dm);
                join
            end
            wait_stream(exp.size());
        end
        rand_ready = 0;
        i_UART_READY = 1;
        checks += 3;
        if (ads_acks - a0 != ea) begin errors++; $display("FAIL rand_ads_acks: got %0d, required %0d", ads_acks - a0, ea); end
        if (mpr_acks - m0 != em) begin errors++; $display("FAIL rand_mpr_acks: got %0d, required %0d", mpr_acks - m0, em); end
        if (got.size() != exp.size()) begin errors++; $display("FAIL rand_len: got %0d, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL rand_byte%0d: got %02h, required %02h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        i_RST = 1; i_ADS_REQ = 0; i_MPR_REQ = 0; i_UART_READY = 1;
        i_ADS_DATA = '0; i_MPR_DATA = '0;
        test_reset();
        test_ads_only();
        test_mpr_only();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_busy_arrival();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
